// File: rtl/tdp_arb_pkg.sv
// Shared types, constants and the round-robin search helper for tdp_port_arbiter.
package tdp_arb_pkg;

  localparam int ARB_W_DATA = 16;
  localparam int ARB_W_ADDR = 16;

  localparam logic CTRL_WR = 1'b1;
  localparam logic CTRL_RD = 1'b0;

  typedef struct packed {
    logic                  ctrl;
    logic [ARB_W_DATA-1:0] data;
    logic [ARB_W_ADDR-1:0] addr;
  } req_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // First set bit of mask at or after ptr, searching cyclically over n entries.
  // Returns ptr when mask is empty; callers qualify the result with |mask.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && mask[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tdp_port_arbiter_if.sv
// Requester-side and memory-port-side handshake bundle for tdp_port_arbiter.
interface tdp_port_arbiter_if #(
  parameter int N      = 2,
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16
);
  localparam int RW = 1 + W_DATA + W_ADDR;

  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*RW-1:0]   req_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [RW-1:0]     mem_req_data;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [W_DATA-1:0] mem_resp_data;
  logic [N-1:0]      dout_valid;
  logic [N-1:0]      dout_ready;
  logic [W_DATA-1:0] dout_data;

  modport slave (
    input  req_valid, req_data, mem_req_ready, mem_resp_valid, mem_resp_data, dout_ready,
    output req_ready, mem_req_valid, mem_req_data, mem_resp_ready, dout_valid, dout_data
  );

  modport master (
    output req_valid, req_data, mem_req_ready, mem_resp_valid, mem_resp_data, dout_ready,
    input  req_ready, mem_req_valid, mem_req_data, mem_resp_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/tdp_arb_tag_fifo.sv
// Register-based FIFO of requester IDs for outstanding reads, oldest at head.
module tdp_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int IDW   = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [IDW-1:0] din,
  output logic           full,
  output logic           empty,
  output logic [IDW-1:0] head,
  output logic [CW-1:0]  count
);

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IDW-1:0] mem_q [DEPTH];
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tdp_port_arbiter.sv
// Round-robin N:1 arbiter for a tdp_port with in-order read-data return routing.
// Optional counters enabled by defining TDP_PORT_ARBITER_STATS_EN.
module tdp_port_arbiter
  import tdp_arb_pkg::*;
#(
  parameter int N         = 2,
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdp_port_arbiter_if.slave bus
`ifdef TDP_PORT_ARBITER_STATS_EN
  ,
  output logic [N*32-1:0]   grant_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int RW = 1 + W_DATA + W_ADDR;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  lock_state_e   state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] pick, grant, head;
  logic [N-1:0]  ctrl_vec, eligible;
  logic [CW-1:0] tag_count;
  logic          fifo_full, fifo_empty;
  logic          any_elig, mem_hs, push, pop, resp_ready;

  always_comb begin
    ctrl_vec = '0;
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      ctrl_vec[i] = bus.req_data[i*RW + RW-1];
      eligible[i] = bus.req_valid[i] && (ctrl_vec[i] == CTRL_WR || !fifo_full);
    end
  end

  assign any_elig = |eligible;
  assign pick     = IW'(rr_pick(8'(eligible), 3'(rr_ptr_q), N));
  assign grant    = (state_q == ST_LOCKED) ? grant_q : pick;

  // Outputs are gated by rst so they drop the moment reset asserts.
  assign bus.mem_req_valid = rst && (state_q == ST_LOCKED || any_elig);
  assign bus.mem_req_data  = bus.req_data[int'(grant)*RW +: RW];
  assign mem_hs            = bus.mem_req_valid && bus.mem_req_ready;
  assign push              = mem_hs && (bus.mem_req_data[RW-1] == CTRL_RD);

  always_comb begin
    bus.req_ready = '0;
    if (bus.mem_req_valid) bus.req_ready[grant] = bus.mem_req_ready;
  end

  // A stalled request pins the grant so the presented request never changes.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_UNLOCKED: if (bus.mem_req_valid && !bus.mem_req_ready) begin
        state_d = ST_LOCKED;
        grant_d = grant;
      end
      ST_LOCKED: if (mem_hs) state_d = ST_UNLOCKED;
      default: state_d = ST_UNLOCKED;
    endcase
    if (mem_hs) rr_ptr_d = (grant == IW'(N-1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_UNLOCKED;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  tdp_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .IDW   (IW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head),
    .count (tag_count)
  );

  assert property (@(posedge clk) disable iff (!rst) tag_count <= CW'(TAG_DEPTH));

  // Responses with nothing outstanding are held off rather than dropped.
  assign resp_ready         = rst && !fifo_empty && bus.dout_ready[head];
  assign bus.mem_resp_ready = resp_ready;
  assign bus.dout_data      = bus.mem_resp_data;
  assign pop                = bus.mem_resp_valid && resp_ready;

  always_comb begin
    bus.dout_valid = '0;
    if (rst && !fifo_empty) bus.dout_valid[head] = bus.mem_resp_valid;
  end

`ifdef TDP_PORT_ARBITER_STATS_EN
  logic [N*32-1:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (mem_hs)
      grant_cnt_d[int'(grant)*32 +: 32] = sat_inc(grant_cnt_q[int'(grant)*32 +: 32]);
    stall_cnt_d = (fifo_full && |(bus.req_valid & ~ctrl_vec)) ? sat_inc(stall_cnt_q)
                                                              : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
